// File: rtl/sprite_table_writer_if.sv
// Connection bundle between the sprite engines, the table writer and the sprite RAM write port.
// The writer attaches through the slave modport, and the engine/RAM side attaches through master.
interface sprite_table_writer_if #(
    parameter int N_SPR  = 8,
    parameter int IDX_W  = 3,
    parameter int DATA_W = 32
);
    logic [N_SPR*DATA_W-1:0] src_data;
    logic [N_SPR-1:0]        src_valid;
    logic                    vblank;
    logic                    force_all;
    logic                    wea;
    logic [IDX_W-1:0]        addra;
    logic [DATA_W-1:0]       dina;
    logic                    busy;
    logic                    commit_done;
    logic                    commit_abort;

    modport master (
        output src_data, src_valid, vblank, force_all,
        input  wea, addra, dina, busy, commit_done, commit_abort
    );

    modport slave (
        input  src_data, src_valid, vblank, force_all,
        output wea, addra, dina, busy, commit_done, commit_abort
    );
endinterface

// File: rtl/sprite_table_writer.sv
// Takes a snapshot of all sprite descriptors at vblank start and writes only the changed
// slots into the sprite RAM, one per cycle, in round-robin order.
module sprite_table_writer #(
    parameter int N_SPR  = 8,
    parameter int IDX_W  = 3,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    sprite_table_writer_if.slave bus
);
    typedef enum logic {IDLE, COMMIT} state_t;

    state_t            state, state_n;
    logic              vblank_d;
    logic              armed;
    logic              force_pend, force_n;
    logic [N_SPR-1:0]  dirty, dirty_n;
    logic [IDX_W-1:0]  rr_ptr, rr_n;
    logic [DATA_W-1:0] snap     [N_SPR];
    logic [DATA_W-1:0] snap_n   [N_SPR];
    logic [DATA_W-1:0] shadow   [N_SPR];
    logic [DATA_W-1:0] shadow_n [N_SPR];
    logic [DATA_W-1:0] eff      [N_SPR];

    logic              wea_r, wea_n;
    logic [IDX_W-1:0]  addra_r, addra_n;
    logic [DATA_W-1:0] dina_r, dina_n;
    logic              done_r, done_n;
    logic              abort_r, abort_n;

    logic              rise;
    logic              found;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  cand;
    int unsigned       idx;

    // armed blocks a false rising edge when vblank is already high as reset releases
    assign rise = bus.vblank & ~vblank_d & armed;

    always_comb begin
        for (int unsigned i = 0; i < N_SPR; i++) begin
            eff[i] = bus.src_valid[i] ? bus.src_data[i*DATA_W +: DATA_W] : '0;
        end
    end

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned off = 0; off < N_SPR; off++) begin
            idx  = (32'(rr_ptr) + off) % N_SPR;
            cand = IDX_W'(idx);
            if (!found && dirty[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_n  = state;
        wea_n    = 1'b0;
        addra_n  = addra_r;
        dina_n   = dina_r;
        done_n   = 1'b0;
        abort_n  = 1'b0;
        dirty_n  = dirty;
        rr_n     = rr_ptr;
        snap_n   = snap;
        shadow_n = shadow;
        force_n  = force_pend | bus.force_all;

        case (state)
            IDLE: begin
                if (rise) begin
                    for (int unsigned i = 0; i < N_SPR; i++) begin
                        snap_n[i]  = eff[i];
                        dirty_n[i] = (eff[i] != shadow[i]) | force_pend;
                    end
                    if (!bus.force_all) force_n = 1'b0;
                    state_n = COMMIT;
                end
            end
            COMMIT: begin
                if (!bus.vblank) begin
                    // unwritten slots keep stale shadows and get re-detected next frame
                    abort_n = |dirty;
                    dirty_n = '0;
                    state_n = IDLE;
                end else if (found) begin
                    wea_n         = 1'b1;
                    addra_n       = sel;
                    dina_n        = snap[sel];
                    shadow_n[sel] = snap[sel];
                    dirty_n[sel]  = 1'b0;
                    rr_n          = (sel == IDX_W'(N_SPR - 1)) ? '0 : sel + IDX_W'(1);
                end else begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            vblank_d   <= 1'b0;
            armed      <= 1'b0;
            force_pend <= 1'b1;
            dirty      <= '0;
            rr_ptr     <= '0;
            wea_r      <= 1'b0;
            addra_r    <= '0;
            dina_r     <= '0;
            done_r     <= 1'b0;
            abort_r    <= 1'b0;
            for (int unsigned i = 0; i < N_SPR; i++) begin
                snap[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            state      <= state_n;
            vblank_d   <= bus.vblank;
            armed      <= armed | ~bus.vblank;
            force_pend <= force_n;
            dirty      <= dirty_n;
            rr_ptr     <= rr_n;
            wea_r      <= wea_n;
            addra_r    <= addra_n;
            dina_r     <= dina_n;
            done_r     <= done_n;
            abort_r    <= abort_n;
            snap       <= snap_n;
            shadow     <= shadow_n;
        end
    end

    assign bus.wea          = wea_r;
    assign bus.addra        = addra_r;
    assign bus.dina         = dina_r;
    assign bus.busy         = (state == COMMIT);
    assign bus.commit_done  = done_r;
    assign bus.commit_abort = abort_r;
endmodule

// File: tb/tb_sprite_table_writer.sv
// Self-checking bench for sprite_table_writer: a frame-level reference model predicts the write
// sequence, the done/abort pulses and busy for every vblank, with directed and random frames.
module tb_sprite_table_writer;
    localparam int N  = 8;
    localparam int IW = 3;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_table_writer_if #(.N_SPR(N), .IDX_W(IW), .DATA_W(DW)) bus ();

    sprite_table_writer #(.N_SPR(N), .IDX_W(IW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] src_d [N];
    logic [N-1:0]  src_v;

    // Reference model state: what the RAM holds, the pending force request and the next slot to serve
    logic [DW-1:0] m_shadow [N];
    bit            m_force;
    int            m_rr;

    function automatic logic [DW-1:0] eff_m(input int i);
        return src_v[i] ? src_d[i] : '0;
    endfunction

    task automatic drive_src();
        for (int i = 0; i < N; i++) bus.src_data[i*DW +: DW] = src_d[i];
        bus.src_valid = src_v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_shadow[i] = '0;
        m_force = 1'b1;
        m_rr    = 0;
    endtask

    task automatic do_reset(input logic vb);
        @(negedge clk);
        reset = 1'b1;
        bus.vblank = vb;
        bus.force_all = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse_force();
        @(negedge clk);
        bus.force_all = 1'b1;
        @(negedge clk);
        bus.force_all = 1'b0;
        m_force = 1'b1;
    endtask

    // One vblank: the snapshot edge E0 plus n_high-1 further edges sampling vblank high
    task automatic run_frame(input int n_high, input bit mutate, input bit force_at_snap, input string tag);
        logic [DW-1:0] snapv [N];
        bit            dirtyv [N];
        int            exp_addr [$];
        logic [DW-1:0] exp_data [$];
        int            obs_addr [$];
        logic [DW-1:0] obs_data [$];
        int            obs_e [$];
        int k, rr0, last, exit_e, exp_done_e, exp_abort_e, done_cnt, abort_cnt, done_e, abort_e, nw;

        k = 0; last = 0; exp_done_e = -1; exp_abort_e = -1;
        done_cnt = 0; abort_cnt = 0; done_e = -1; abort_e = -1;
        rr0 = m_rr;
        for (int i = 0; i < N; i++) begin
            snapv[i]  = eff_m(i);
            dirtyv[i] = (snapv[i] != m_shadow[i]) || m_force;
            if (dirtyv[i]) k++;
        end
        m_force = force_at_snap;
        for (int off = 0; off < N; off++) begin
            int i;
            i = (rr0 + off) % N;
            if (dirtyv[i] && exp_addr.size() < n_high - 1) begin
                exp_addr.push_back(i);
                exp_data.push_back(snapv[i]);
                m_shadow[i] = snapv[i];
                last = i;
            end
        end
        if (exp_addr.size() > 0) m_rr = (last + 1) % N;
        if (k <= n_high - 2) begin
            exp_done_e = k + 1;
            exit_e = k + 1;
        end else begin
            exit_e = n_high;
            if (k > n_high - 1) exp_abort_e = n_high;
        end

        @(negedge clk);
        bus.vblank = 1'b1;
        bus.force_all = force_at_snap;
        for (int t = 1; t <= n_high + 3; t++) begin
            int e;
            @(negedge clk);
            e = t - 1;
            if (t == 1) begin
                bus.force_all = 1'b0;
                if (mutate) begin
                    for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) src_d[i] = $urandom;
                    drive_src();
                end
            end
            bus.vblank = (t < n_high);
            if (bus.wea === 1'b1) begin
                obs_addr.push_back(int'(bus.addra));
                obs_data.push_back(bus.dina);
                obs_e.push_back(e);
            end
            if (bus.commit_done === 1'b1) begin done_cnt++; done_e = e; end
            if (bus.commit_abort === 1'b1) begin abort_cnt++; abort_e = e; end
            checks++;
            if (bus.busy !== ((e < exit_e) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL %s busy after edge %0d: got %b want %b", tag, e, bus.busy, (e < exit_e));
            end
        end

        checks++;
        if (obs_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL %s write count: got %0d want %0d", tag, obs_addr.size(), exp_addr.size());
        end
        nw = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int w = 0; w < nw; w++) begin
            checks++;
            if (obs_addr[w] != exp_addr[w] || obs_data[w] !== exp_data[w] || obs_e[w] != w + 1) begin
                errors++;
                $display("FAIL %s write %0d: got addr %0d data %h edge %0d want addr %0d data %h edge %0d",
                         tag, w, obs_addr[w], obs_data[w], obs_e[w], exp_addr[w], exp_data[w], w + 1);
            end
        end
        checks++;
        if (done_cnt != ((exp_done_e >= 0) ? 1 : 0) || done_e != exp_done_e) begin
            errors++;
            $display("FAIL %s commit_done: got %0d pulses at edge %0d want edge %0d", tag, done_cnt, done_e, exp_done_e);
        end
        checks++;
        if (abort_cnt != ((exp_abort_e >= 0) ? 1 : 0) || abort_e != exp_abort_e) begin
            errors++;
            $display("FAIL %s commit_abort: got %0d pulses at edge %0d want edge %0d", tag, abort_cnt, abort_e, exp_abort_e);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++;
        if ({bus.wea, bus.addra, bus.dina, bus.busy, bus.commit_done, bus.commit_abort} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got wea %b addra %0d dina %h busy %b done %b abort %b want all 0",
                     bus.wea, bus.addra, bus.dina, bus.busy, bus.commit_done, bus.commit_abort);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.wea !== 1'b0) begin
                errors++;
                $display("FAIL vblank_high_out_of_reset: got busy %b wea %b want 0 0", bus.busy, bus.wea);
            end
        end
        @(negedge clk);
        bus.vblank = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_first();
        for (int i = 0; i < N; i++) src_d[i] = 32'hC0DE_0100 + 32'(i * 17);
        src_v = '1;
        drive_src();
        run_frame(21, 1'b0, 1'b0, "full_first");
    endtask

    task automatic test_single_change();
        src_d[5] = src_d[5] ^ 32'h0F0F_1234;
        drive_src();
        run_frame(20, 1'b0, 1'b0, "single_change");
    endtask

    task automatic test_invalidate();
        src_v[2] = 1'b0;
        drive_src();
        run_frame(20, 1'b0, 1'b0, "invalidate");
    endtask

    task automatic test_abort_resume();
        do_reset(1'b0);
        run_frame(3, 1'b0, 1'b0, "abort_short");
        run_frame(21, 1'b0, 1'b0, "abort_resume");
    endtask

    task automatic test_force();
        pulse_force();
        run_frame(21, 1'b0, 1'b0, "force_mid_frame");
        run_frame(6, 1'b0, 1'b1, "force_at_snapshot");
        run_frame(21, 1'b0, 1'b0, "force_after_snapshot");
    endtask

    task automatic test_reset_mid_commit();
        int want_addr;
        pulse_force();
        want_addr = (m_rr + 3) % N;
        @(negedge clk);
        bus.vblank = 1'b1;
        for (int t = 1; t <= 5; t++) @(negedge clk);
        checks++;
        if (bus.wea !== 1'b1 || int'(bus.addra) != want_addr) begin
            errors++;
            $display("FAIL midreset_4th_write: got wea %b addra %0d want 1 %0d", bus.wea, bus.addra, want_addr);
        end
        reset = 1'b1;
        bus.vblank = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.wea, bus.addra, bus.dina, bus.busy, bus.commit_done, bus.commit_abort} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got wea %b addra %0d dina %h busy %b want all 0",
                     bus.wea, bus.addra, bus.dina, bus.busy);
        end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        run_frame(21, 1'b1, 1'b0, "after_reset_all");
        run_frame(21, 1'b0, 1'b0, "after_reset_pickup");
    endtask

    task automatic test_random();
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) src_d[i] = $urandom;
                if ($urandom_range(0, 7) == 0) src_v[i] = ~src_v[i];
            end
            drive_src();
            if ($urandom_range(0, 5) == 0) pulse_force();
            run_frame(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), "random");
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b0;
        bus.vblank = 1'b0;
        bus.force_all = 1'b0;
        src_v = '1;
        for (int i = 0; i < N; i++) src_d[i] = '0;
        drive_src();
        model_reset();
        test_reset();
        test_full_first();
        test_single_change();
        test_invalidate();
        test_abort_resume();
        test_force();
        test_reset_mid_commit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
